// File: rtl/t_chan_mon_pkg.sv
// Shared types for the multi-channel handshake monitor: lane state and stall counter.
package t_chan_mon_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } lane_state_e;

  typedef logic [7:0] stall_cnt_t;

  localparam int STALL_MAX = 255;

endpackage

// File: rtl/t_chan_mon_lane.sv
// One monitored valid/ready stream: IDLE/WAIT FSM, saturating transfer counter, sticky errors.
// Defining T_CHAN_MON_ASSERT_EN adds per-lane immediate assertions on first error set.
module t_chan_mon_lane
  import t_chan_mon_pkg::*;
#(
  parameter int DW      = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             valid,
  input  logic             ready,
  input  logic [DW-1:0]    data,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             err_stable,
  output logic             err_drop,
  output logic             err_timeout
);

  localparam stall_cnt_t      TO8 = stall_cnt_t'(TIMEOUT);
  localparam logic [8:0]      TO9 = 9'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  lane_state_e      state, state_n;
  logic [DW-1:0]    latch, latch_n;
  stall_cnt_t       stall, stall_n;
  logic [8:0]       stall_sum;
  logic             inc, set_s, set_d, set_t;
  logic [CNT_W-1:0] cnt_base, count_n;

  assign stall_sum = {1'b0, stall} + 9'd1;

  always_comb begin
    state_n = state;
    latch_n = latch;
    stall_n = stall;
    inc     = 1'b0;
    set_s   = 1'b0;
    set_d   = 1'b0;
    set_t   = 1'b0;
    case (state)
      IDLE: begin
        if (valid) begin
          if (ready) begin
            inc = 1'b1;
          end else begin
            latch_n = data;
            stall_n = 8'd1;
            state_n = WAIT;
            set_t   = (TIMEOUT == 1);
          end
        end
      end
      WAIT: begin
        if (!valid) begin
          set_d   = 1'b1;
          stall_n = 8'd0;
          state_n = IDLE;
        end else begin
          // The stability check still applies on the accepting cycle.
          set_s = (data != latch);
          if (ready) begin
            inc     = 1'b1;
            stall_n = 8'd0;
            state_n = IDLE;
          end else begin
            stall_n = (stall_sum >= TO9) ? TO8 : stall_sum[7:0];
            set_t   = (stall_sum == TO9);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Clear takes effect before the same-cycle event.
  assign cnt_base = clear ? '0 : count;
  assign count_n  = (inc && (cnt_base != '1)) ? cnt_base + CNT_ONE : cnt_base;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state       <= IDLE;
      latch       <= '0;
      stall       <= '0;
      count       <= '0;
      err_stable  <= 1'b0;
      err_drop    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      latch       <= latch_n;
      stall       <= stall_n;
      count       <= count_n;
      err_stable  <= (err_stable  & ~clear) | set_s;
      err_drop    <= (err_drop    & ~clear) | set_d;
      err_timeout <= (err_timeout & ~clear) | set_t;
    end
  end

`ifdef T_CHAN_MON_ASSERT_EN
  function automatic void f_assert_stable$();
    assert (0);
  endfunction

  function automatic void f_assert_drop$();
    assert (0);
  endfunction

  function automatic void f_assert_timeout$();
    assert (0);
  endfunction

  always @(posedge clk) begin
    if (reset_l) begin
      if (set_s && (!err_stable  || clear)) f_assert_stable$();
      if (set_d && (!err_drop    || clear)) f_assert_drop$();
      if (set_t && (!err_timeout || clear)) f_assert_timeout$();
    end
  end
`endif

endmodule

// File: rtl/t_chan_mon_multi.sv
// CHANNELS independent handshake monitor lanes; slices the buses and ORs the error bits.
// Optional per-lane assertions: define T_CHAN_MON_ASSERT_EN.
module t_chan_mon_multi
  import t_chan_mon_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DW       = 8,
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 15
) (
  input  logic                      clk,
  input  logic                      reset_l,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_ready,
  input  logic [CHANNELS*DW-1:0]    in_data,
  input  logic                      clear,
  output logic [CHANNELS*CNT_W-1:0] xfer_count,
  output logic [CHANNELS-1:0]       err_stable,
  output logic [CHANNELS-1:0]       err_drop,
  output logic [CHANNELS-1:0]       err_timeout,
  output logic                      any_err
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    t_chan_mon_lane #(
      .DW      (DW),
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
    ) u_lane (
      .clk         (clk),
      .reset_l     (reset_l),
      .valid       (in_valid[i]),
      .ready       (in_ready[i]),
      .data        (in_data[i*DW +: DW]),
      .clear       (clear),
      .count       (xfer_count[i*CNT_W +: CNT_W]),
      .err_stable  (err_stable[i]),
      .err_drop    (err_drop[i]),
      .err_timeout (err_timeout[i])
    );
  end

  assign any_err = (|err_stable) | (|err_drop) | (|err_timeout);

endmodule

// File: tb/tb_t_chan_mon_multi.sv
// Bench for t_chan_mon_multi: a 4-lane default instance and a 2-lane CNT_W=4, TIMEOUT=1 instance.
module tb_t_chan_mon_multi;

  logic clk = 1'b0;
  logic reset_l = 1'b1;
  always #5 clk = ~clk;

  // Instance A: defaults.
  logic [3:0]  va, ra;
  logic [31:0] da;
  logic        clra;
  logic [63:0] cnt_a;
  logic [3:0]  es_a, ed_a, et_a;
  logic        any_a;

  // Instance B: narrow counter, single-cycle timeout.
  logic [1:0]  vb, rb;
  logic [15:0] db;
  logic        clrb;
  logic [7:0]  cnt_b;
  logic [1:0]  es_b, ed_b, et_b;
  logic        any_b;

  t_chan_mon_multi #(.CHANNELS(4), .DW(8), .CNT_W(16), .TIMEOUT(15)) dut_a (
    .clk(clk), .reset_l(reset_l), .in_valid(va), .in_ready(ra), .in_data(da),
    .clear(clra), .xfer_count(cnt_a), .err_stable(es_a), .err_drop(ed_a),
    .err_timeout(et_a), .any_err(any_a)
  );

  t_chan_mon_multi #(.CHANNELS(2), .DW(8), .CNT_W(4), .TIMEOUT(1)) dut_b (
    .clk(clk), .reset_l(reset_l), .in_valid(vb), .in_ready(rb), .in_data(db),
    .clear(clrb), .xfer_count(cnt_b), .err_stable(es_b), .err_drop(ed_b),
    .err_timeout(et_b), .any_err(any_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: a pending transfer per lane plus counts of stalled edges.
  bit         m_pend [2][4];
  logic [7:0] m_pdata[2][4];
  int         m_stall[2][4];
  int         m_cnt  [2][4];
  bit         m_es   [2][4];
  bit         m_ed   [2][4];
  bit         m_et   [2][4];

  task automatic model_reset();
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 4; i++) begin
        m_pend[u][i] = 0; m_pdata[u][i] = 8'h00; m_stall[u][i] = 0;
        m_cnt[u][i] = 0; m_es[u][i] = 0; m_ed[u][i] = 0; m_et[u][i] = 0;
      end
  endtask

  task automatic model_step(input int u, input int nch, input int cmax, input int tmo,
                            input logic [3:0] v, input logic [3:0] r,
                            input logic [31:0] d, input logic clr);
    logic [7:0] dv;
    for (int i = 0; i < nch; i++) begin
      dv = d[i*8 +: 8];
      if (clr) begin
        m_cnt[u][i] = 0; m_es[u][i] = 0; m_ed[u][i] = 0; m_et[u][i] = 0;
      end
      if (m_pend[u][i]) begin
        if (!v[i]) begin
          m_ed[u][i] = 1;
          m_pend[u][i] = 0;
        end else begin
          if (dv != m_pdata[u][i]) m_es[u][i] = 1;
          if (r[i]) begin
            if (m_cnt[u][i] < cmax) m_cnt[u][i]++;
            m_pend[u][i] = 0;
          end else begin
            m_stall[u][i]++;
            if (m_stall[u][i] == tmo) m_et[u][i] = 1;
          end
        end
      end else if (v[i]) begin
        if (r[i]) begin
          if (m_cnt[u][i] < cmax) m_cnt[u][i]++;
        end else begin
          m_pend[u][i] = 1;
          m_pdata[u][i] = dv;
          m_stall[u][i] = 1;
          if (tmo == 1) m_et[u][i] = 1;
        end
      end
    end
  endtask

  always @(posedge clk or negedge reset_l) begin
    if (!reset_l) model_reset();
    else begin
      model_step(0, 4, 65535, 15, va, ra, da, clra);
      model_step(1, 2, 15, 1, {2'b00, vb}, {2'b00, rb}, {16'h0000, db}, clrb);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    bit anya, anyb;
    anya = 0; anyb = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("a_cnt%0d", i), 32'(cnt_a[i*16 +: 16]), 32'(m_cnt[0][i]));
      chk($sformatf("a_stable%0d", i), 32'(es_a[i]), 32'(m_es[0][i]));
      chk($sformatf("a_drop%0d", i), 32'(ed_a[i]), 32'(m_ed[0][i]));
      chk($sformatf("a_timeout%0d", i), 32'(et_a[i]), 32'(m_et[0][i]));
      anya = anya | m_es[0][i] | m_ed[0][i] | m_et[0][i];
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("b_cnt%0d", i), 32'(cnt_b[i*4 +: 4]), 32'(m_cnt[1][i]));
      chk($sformatf("b_stable%0d", i), 32'(es_b[i]), 32'(m_es[1][i]));
      chk($sformatf("b_drop%0d", i), 32'(ed_b[i]), 32'(m_ed[1][i]));
      chk($sformatf("b_timeout%0d", i), 32'(et_b[i]), 32'(m_et[1][i]));
      anyb = anyb | m_es[1][i] | m_ed[1][i] | m_et[1][i];
    end
    chk("a_any", 32'(any_a), 32'(anya));
    chk("b_any", 32'(any_b), 32'(anyb));
  end

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic idle_all();
    va = '0; ra = '0; da = '0; clra = 1'b0;
    vb = '0; rb = '0; db = '0; clrb = 1'b0;
  endtask

  initial begin
    idle_all();
    #1 reset_l = 1'b0;
    tick(2);
    chk("reset_cnt_a", cnt_a[31:0], 32'h0);
    chk("reset_any_a", 32'(any_a), 32'h0);
    reset_l = 1'b1;
    tick();

    // Five back-to-back transfers on channel 0.
    va[0] = 1'b1; ra[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      da[7:0] = 8'(i + 1);
      tick();
    end
    va[0] = 1'b0; ra[0] = 1'b0;
    chk("t1_cnt0", 32'(cnt_a[15:0]), 32'd5);
    chk("t1_cnt1", 32'(cnt_a[31:16]), 32'd0);
    chk("t1_any", 32'(any_a), 32'd0);

    // Channel 1 stalls three cycles, then accepted.
    va[1] = 1'b1; da[15:8] = 8'hA5;
    tick(3);
    ra[1] = 1'b1;
    tick();
    va[1] = 1'b0; ra[1] = 1'b0;
    chk("t2_cnt1", 32'(cnt_a[31:16]), 32'd1);
    chk("t2_any", 32'(any_a), 32'd0);

    // Channel 2 changes data while stalled.
    va[2] = 1'b1; da[23:16] = 8'h11;
    tick();
    da[23:16] = 8'h22;
    tick();
    chk("t3_stable2", 32'(es_a[2]), 32'd1);
    ra[2] = 1'b1;
    tick();
    va[2] = 1'b0; ra[2] = 1'b0;
    chk("t3_cnt2", 32'(cnt_a[47:32]), 32'd1);
    chk("t3_any", 32'(any_a), 32'd1);

    // Channel 3 drops valid while stalled.
    va[3] = 1'b1; da[31:24] = 8'h3C;
    tick();
    va[3] = 1'b0;
    tick();
    chk("t4_drop3", 32'(ed_a[3]), 32'd1);

    // Channel 0 stalls until timeout.
    va[0] = 1'b1; da[7:0] = 8'h77;
    tick(14);
    chk("t4_timeout0_early", 32'(et_a[0]), 32'd0);
    tick();
    chk("t4_timeout0", 32'(et_a[0]), 32'd1);
    ra[0] = 1'b1;
    tick();
    va[0] = 1'b0; ra[0] = 1'b0;
    chk("t4_cnt0", 32'(cnt_a[15:0]), 32'd6);

    // Clear coinciding with a channel-1 transfer.
    clra = 1'b1; va[1] = 1'b1; ra[1] = 1'b1;
    tick();
    clra = 1'b0; va[1] = 1'b0; ra[1] = 1'b0;
    chk("t5_errs", 32'({es_a, ed_a, et_a}), 32'h0);
    chk("t5_cnt1", 32'(cnt_a[31:16]), 32'd1);
    chk("t5_cnt0", 32'(cnt_a[15:0]), 32'd0);

    // Clear coinciding with a drop: the flag survives.
    va[3] = 1'b1;
    tick();
    clra = 1'b1; va[3] = 1'b0;
    tick();
    clra = 1'b0;
    chk("t5_clear_drop3", 32'(ed_a[3]), 32'd1);

    // Narrow counter saturation and single-cycle timeout.
    vb[0] = 1'b1; rb[0] = 1'b1;
    for (int i = 0; i < 17; i++) begin
      db[7:0] = 8'(i);
      tick();
    end
    vb[0] = 1'b0; rb[0] = 1'b0;
    chk("t6_sat", 32'(cnt_b[3:0]), 32'hF);
    vb[1] = 1'b1; db[15:8] = 8'h5A;
    tick();
    chk("t6_timeout1", 32'(et_b[1]), 32'd1);
    rb[1] = 1'b1;
    tick();
    vb[1] = 1'b0; rb[1] = 1'b0;
    chk("t6_cnt1", 32'(cnt_b[7:4]), 32'd1);

    // Reset pulsed mid-stall.
    va[1] = 1'b1; da[15:8] = 8'hC3;
    tick(2);
    #1 reset_l = 1'b0;
    #1;
    chk("t7_cnt_a", cnt_a[31:0], 32'h0);
    chk("t7_errs_a", 32'({es_a, ed_a, et_a}), 32'h0);
    chk("t7_cnt_b", 32'(cnt_b), 32'h0);
    chk("t7_any", 32'({any_a, any_b}), 32'h0);
    tick(2);
    va[1] = 1'b0;
    reset_l = 1'b1;
    tick(2);
    chk("t7_nodrop", 32'(ed_a[1]), 32'd0);
    chk("t7_cnt1", 32'(cnt_a[31:16]), 32'd0);

    idle_all();
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
